// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: controller states and
// the position of the power-on / lock-loss bit in the cause vector.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  // The power-on / lock-loss cause sits just above the per-source bits.
  function automatic int cause_por(input int num_src);
    return num_src;
  endfunction

endpackage

// File: rtl/reset_src_sync.sv
// Synchroniser for one asynchronous reset request, with either a level
// trigger or a registered falling-edge trigger on the synced value.
module reset_src_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic trig
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync[SYNC_STAGES-1];

  generate
    if (EDGE) begin : g_edge
      logic fall;

      // Looks one stage ahead so the pulse rises in the cycle q first reads 0;
      // zeroed flops after reset mean no phantom edge on release.
      always_ff @(posedge clk) begin
        if (reset) begin
          fall <= 1'b0;
        end else begin
          fall <= sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES-2];
        end
      end

      assign trig = fall;
    end else begin : g_level
      assign trig = sync[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: merges PLL lock with external reset sources, stretches
// the reset by a hold time, then releases domains one by one.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                 NUM_SRC        = 2,
  parameter logic [NUM_SRC-1:0] SRC_EDGE_MASK  = 2'b01,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 HOLD_CYCLES    = 255,
  parameter int                 NUM_OUT        = 3,
  parameter int                 STAGGER_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               cause_clear,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [NUM_SRC:0]   rst_cause,
  output logic               ready
);

  localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int STAG_W    = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W     = $clog2(NUM_OUT + 1);
  localparam int CAUSE_POR = cause_por(NUM_SRC);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUT - 1);

  logic [NUM_SRC-1:0] src_trig;
  logic [NUM_SRC-1:0] src_sync_unused;
  logic               lock_s;
  logic               lock_trig_unused;
  logic               lock_loss;
  logic               trig;
  logic [NUM_SRC:0]   cause_set;

  state_t             state, state_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic [STAG_W-1:0]  stag_cnt, stag_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [NUM_OUT-1:0] rst_next;
  logic               ready_next;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reset_src_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE       (SRC_EDGE_MASK[i])
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (src_in[i]),
      .q    (src_sync_unused[i]),
      .trig (src_trig[i])
    );
  end

  reset_src_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE       (1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pll_locked),
    .q    (lock_s),
    .trig (lock_trig_unused)
  );

  // Lock loss only counts as a new event once we have started releasing;
  // in ASSERT it simply keeps the hold counter at zero.
  assign lock_loss = ~lock_s & (state != ASSERT);
  assign trig      = (|src_trig) | lock_loss;
  assign cause_set = {lock_loss, src_trig};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      hold_cnt  <= '0;
      stag_cnt  <= '0;
      idx       <= '0;
      rst_out   <= '1;
      ready     <= 1'b0;
      rst_cause <= '0;
      rst_cause[CAUSE_POR] <= 1'b1;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      stag_cnt  <= stag_next;
      idx       <= idx_next;
      rst_out   <= rst_next;
      ready     <= ready_next;
      rst_cause <= cause_set | (rst_cause & ~{(NUM_SRC + 1){cause_clear}});
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    stag_next  = stag_cnt;
    idx_next   = idx;
    if (trig) begin
      state_next = ASSERT;
      hold_next  = '0;
      stag_next  = '0;
      idx_next   = '0;
    end else begin
      case (state)
        ASSERT: begin
          if (!lock_s) begin
            hold_next = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_next = '0;
            stag_next = '0;
            idx_next  = IDX_W'(1);
            state_next = (NUM_OUT == 1) ? RUN : STAGGER;
          end else begin
            hold_next = hold_cnt + HOLD_W'(1);
          end
        end
        STAGGER: begin
          if (stag_cnt == STAG_LAST) begin
            stag_next = '0;
            idx_next  = idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state_next = RUN;
            end
          end else begin
            stag_next = stag_cnt + STAG_W'(1);
          end
        end
        RUN: begin
          state_next = RUN;
        end
        default: begin
          state_next = ASSERT;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so every
  // domain reset comes straight off a flop.
  always_comb begin
    rst_next   = '1;
    ready_next = 1'b0;
    case (state_next)
      STAGGER: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          rst_next[i] = (IDX_W'(i) >= idx_next);
        end
      end
      RUN: begin
        rst_next   = '0;
        ready_next = 1'b1;
      end
      default: begin
        rst_next   = '1;
        ready_next = 1'b0;
      end
    endcase
  end

endmodule
